ext_bus_arbiter: RTL and testbench
==================================

EXT_BUS_ARBITER -- requirements
Module: ext_bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesting external address generators; legal range 2..8.
REQ-002 Parameter DATA_W, default 32: databus data width.
REQ-003 Parameter ADDR_W, default 32: databus address width (IO address width).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  N_REQ  per-requester databus request, held high for whole transfer.
REQ-007 req_addr  input  N_REQ*ADDR_W  packed per-requester addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-008 req_wdata  input  N_REQ*DATA_W  packed per-requester write data.
REQ-009 req_wstrb  input  N_REQ*DATA_W/8  packed per-requester write strobes (all-zero = read).
REQ-010 req_ready  output  N_REQ  per-requester ready, routed from m_ready to owner only.
REQ-011 req_rdata  output  DATA_W  read data, broadcast to all requesters.
REQ-012 m_valid  output  1  shared databus valid.
REQ-013 m_addr  output  ADDR_W  shared databus address.
REQ-014 m_wdata  output  DATA_W  shared databus write data.
REQ-015 m_wstrb  output  DATA_W/8  shared databus write strobes.
REQ-016 m_ready  input  1  shared databus ready.
REQ-017 m_rdata  input  DATA_W  shared databus read data.
REQ-018 grant  output  N_REQ  registered one-hot owner indication, zero when idle.
REQ-019 busy  output  1  high while state is GRANT.

Function
REQ-020 FSM SHALL have two states: IDLE and GRANT; any illegal encoding SHALL go to IDLE next cycle.
REQ-021 IDLE: if any req_valid high, SHALL select owner by round-robin search starting at index ptr, wrapping modulo N_REQ, lowest qualifying index wins; next cycle state=GRANT, grant=onehot(owner).
REQ-022 IDLE: m_valid, m_addr, m_wdata, m_wstrb SHALL be 0 and req_ready SHALL be all-zero.
REQ-023 Arbitration latency SHALL be exactly one cycle: request first seen at edge t drives m_valid from cycle t+1.
REQ-024 GRANT: m_valid=req_valid[owner], m_addr/m_wdata/m_wstrb = owner's fields, combinationally.
REQ-025 GRANT: req_ready[owner]=m_ready; req_ready of all other requesters SHALL be 0.
REQ-026 req_rdata SHALL equal m_rdata in all states.
REQ-027 Grant SHALL be held (no preemption) while req_valid[owner] is high, regardless of m_ready or other requests.
REQ-028 GRANT with req_valid[owner] low: next cycle state=IDLE, grant=0, ptr=(owner+1) mod N_REQ; one idle bubble between owners is mandatory.
REQ-029 ptr SHALL be log2(N_REQ) bits wide, SHALL update only on release, and SHALL wrap from N_REQ-1 to 0.
REQ-030 A request arriving during GRANT SHALL wait; no request SHALL be lost or starved: worst-case wait is N_REQ-1 completed transfers plus bubbles.
REQ-031 Owner dropping and re-raising req_valid in consecutive cycles SHALL be treated as release; it re-competes with ptr already advanced.

Reset
REQ-032 On rst high: state=IDLE, grant=0, ptr=0, busy=0; all m_* outputs and req_ready SHALL be 0 while rst is high.
REQ-033 rst asserted mid-transfer SHALL abort ownership immediately (asynchronously); after release, arbitration restarts from index 0.

Structure
REQ-034 State encodings (IDLE, GRANT) and their width SHALL be defined in the shared versat header/package alongside existing FSM and width constants.
REQ-035 Round-robin selection SHALL be a sub-module rr_select (inputs req vector, ptr; outputs one-hot and index), combinational, reusable by other versat arbiters.
REQ-036 Block SHALL be placed between the ext address generators' databus ports and the single external databus master port; no internal buffering of data.

Verification
REQ-037 Single requester: req_valid=0001, addr 0x100, m_ready pulsed 3 times -> m_valid from cycle+1, m_addr=0x100, req_ready[0] mirrors m_ready, others 0.
REQ-038 Simultaneous requests 1111 after reset -> owner order 0,1,2,3 with one idle bubble between each; grant one-hot each time.
REQ-039 Requester 1 owns, requester 0 raises valid mid-transfer with m_ready=0 for 10 cycles -> grant stays 0010, req_ready[0]=0 throughout.
REQ-040 Wrap: ptr=3, requests 1001 -> owner 3 first, then 0; ptr wraps to 0 then 1.
REQ-041 Read path: owner 2, wstrb=0, m_rdata=0xDEADBEEF -> req_rdata=0xDEADBEEF on all requesters, only req_ready[2] high.
REQ-042 rst pulsed while owner 2 active -> m_valid, grant, req_ready zero during rst; after rst, pending 0100|0001 grants requester 0 first.

Source files
------------

// File: rtl/ext_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ext_bus_arbiter_pkg
// Brief    : Shared FSM encodings and width helpers for the external databus
//            arbiter and its round-robin selector.
// Revision : 1.0 - initial release
// ============================================================================
package ext_bus_arbiter_pkg;

  // Arbiter FSM encoding; one-hot so the two unused codes are detectable.
  localparam int              ST_W     = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'b01;
  localparam logic [ST_W-1:0] ST_GRANT = 2'b10;

  // Legal requester count range.
  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 8;

  // Width of the round-robin pointer / owner index for n requesters.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ext_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ext_bus_arbiter_if
// Brief    : Requester-side and shared-databus signals of the external bus
//            arbiter. 'master' is the arbiter view, 'slave' the environment
//            (address generators plus external databus) view.
// Revision : 1.0 - initial release
// ============================================================================
interface ext_bus_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // requester side
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ*STRB_W-1:0] req_wstrb;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       req_rdata;

  // shared databus side
  logic                    m_valid;
  logic [ADDR_W-1:0]       m_addr;
  logic [DATA_W-1:0]       m_wdata;
  logic [STRB_W-1:0]       m_wstrb;
  logic                    m_ready;
  logic [DATA_W-1:0]       m_rdata;

  // status
  logic [N_REQ-1:0]        grant;
  logic                    busy;

  modport master (
    input  req_valid, req_addr, req_wdata, req_wstrb, m_ready, m_rdata,
    output req_ready, req_rdata, m_valid, m_addr, m_wdata, m_wstrb, grant, busy
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_wstrb, m_ready, m_rdata,
    input  req_ready, req_rdata, m_valid, m_addr, m_wdata, m_wstrb, grant, busy
  );

endinterface
`default_nettype wire

// File: rtl/ext_bus_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_select
// Brief    : Combinational round-robin selector. Searches i_req starting at
//            i_ptr, wrapping modulo N; first set bit wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_select #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [N-1:0] w_rot;
  logic [PW:0]  w_sum;
  logic         w_found;

  // Rotating a doubled copy right by ptr puts the search start at bit 0.
  assign w_rot = N'({i_req, i_req} >> i_ptr);
  assign o_any = |i_req;

  // Priority-find in rotated order, then map back to the absolute index.
  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, i_ptr} + (PW+1)'(k);
      end
    end
    if (w_sum >= (PW+1)'(N)) begin
      w_sum = w_sum - (PW+1)'(N);
    end
    o_idx    = w_sum[PW-1:0];
    o_onehot = o_any ? (N'(1) << o_idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/ext_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ext_bus_arbiter
// Brief    : Round-robin arbiter giving N_REQ external address generators
//            access to one external databus master port. Ownership is held
//            until the owner drops req_valid; an idle cycle separates owners.
//            Data paths are pure muxes, nothing is buffered.
// Revision : 1.0 - initial release
// ============================================================================
module ext_bus_arbiter
  import ext_bus_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  ext_bus_arbiter_if.master   bus
);

  localparam int PW     = ptr_width(N_REQ);
  localparam int STRB_W = DATA_W / 8;

  logic [ST_W-1:0]   r_state;
  logic [N_REQ-1:0]  r_grant;
  logic [PW-1:0]     r_owner;
  logic [PW-1:0]     r_ptr;

  logic [N_REQ-1:0]  w_sel_oh;
  logic [PW-1:0]     w_sel_idx;
  logic              w_sel_any;
  logic              w_granted;
  logic              w_owner_valid;

  logic              w_m_valid;
  logic [ADDR_W-1:0] w_m_addr;
  logic [DATA_W-1:0] w_m_wdata;
  logic [STRB_W-1:0] w_m_wstrb;
  logic [N_REQ-1:0]  w_req_ready;

  rr_select #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr_select (
    .i_req    (bus.req_valid),
    .i_ptr    (r_ptr),
    .o_onehot (w_sel_oh),
    .o_idx    (w_sel_idx),
    .o_any    (w_sel_any)
  );

  assign w_granted     = (r_state == ST_GRANT);
  assign w_owner_valid = |(r_grant & bus.req_valid);

  // Arbitration FSM: grant on any request in IDLE, release when owner drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_any) begin
            r_state <= ST_GRANT;
            r_grant <= w_sel_oh;
            r_owner <= w_sel_idx;
          end
        end
        ST_GRANT: begin
          if (!w_owner_valid) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= (r_owner == PW'(N_REQ-1)) ? '0 : r_owner + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

  // Route the owner's request onto the shared bus; everything is zero when idle.
  always_comb begin
    w_m_valid   = 1'b0;
    w_m_addr    = '0;
    w_m_wdata   = '0;
    w_m_wstrb   = '0;
    w_req_ready = '0;
    if (w_granted) begin
      w_m_valid   = w_owner_valid;
      w_req_ready = r_grant & {N_REQ{bus.m_ready}};
      for (int i = 0; i < N_REQ; i++) begin
        if (r_grant[i]) begin
          w_m_addr  = bus.req_addr [i*ADDR_W +: ADDR_W];
          w_m_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
          w_m_wstrb = bus.req_wstrb[i*STRB_W +: STRB_W];
        end
      end
    end
  end

  assign bus.m_valid   = w_m_valid;
  assign bus.m_addr    = w_m_addr;
  assign bus.m_wdata   = w_m_wdata;
  assign bus.m_wstrb   = w_m_wstrb;
  assign bus.req_ready = w_req_ready;
  assign bus.req_rdata = bus.m_rdata;
  assign bus.grant     = r_grant;
  assign bus.busy      = w_granted;

endmodule
`default_nettype wire

// File: tb/tb_ext_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_bus_arbiter
// Brief    : Self-checking bench for ext_bus_arbiter (N_REQ=4, 32-bit bus).
//            Directed stimulus pushes expected transfers into a queue; a
//            negedge monitor pops and compares on every accepted transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  typedef struct {
    logic [3:0]  grant;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  rdy;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  exp_t sbq[$];
  exp_t mon_e;

  logic [31:0] addr_tab  [4];
  logic [31:0] wdata_tab [4];
  logic [3:0]  wstrb_tab [4];

  ext_bus_arbiter_if #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  ext_bus_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for any grant, then check it names the expected owner.
  task automatic wait_grant(input int o);
    int n;
    n = 0;
    while (bus.grant == 4'b0 && n < 16) begin
      tick();
      n++;
    end
    check($sformatf("grant_owner%0d", o), bus.grant, 4'(1) << o);
  endtask

  // One accepted beat for owner o, then release and check the idle bubble.
  task automatic do_xfer(input int o, input logic [31:0] rdata);
    exp_t e;
    e.grant = 4'(1) << o;
    e.addr  = addr_tab[o];
    e.wdata = wdata_tab[o];
    e.wstrb = wstrb_tab[o];
    e.rdy   = 4'(1) << o;
    e.rdata = rdata;
    bus.m_rdata = rdata;
    bus.m_ready = 1'b1;
    sbq.push_back(e);
    tick();
    bus.m_ready      = 1'b0;
    bus.req_valid[o] = 1'b0;
    tick();
    check($sformatf("bubble_grant_after%0d", o), bus.grant, 4'b0);
    check($sformatf("bubble_mvalid_after%0d", o), bus.m_valid, 1'b0);
  endtask

  // Scoreboard monitor: every accepted bus beat must match the queue head.
  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: beat addr %0h grant %0h, expected none", bus.m_addr, bus.grant);
      end else begin
        mon_e = sbq.pop_front();
        check("sb_grant", bus.grant, mon_e.grant);
        check("sb_addr", bus.m_addr, mon_e.addr);
        check("sb_wdata", bus.m_wdata, mon_e.wdata);
        check("sb_wstrb", bus.m_wstrb, mon_e.wstrb);
        check("sb_req_ready", bus.req_ready, mon_e.rdy);
        check("sb_req_rdata", bus.req_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    addr_tab  = '{32'h0000_0100, 32'h0000_1110, 32'h0000_2220, 32'h0000_3330};
    wdata_tab = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    wstrb_tab = '{4'hF, 4'h3, 4'h0, 4'hC};
    bus.req_valid = '0;
    bus.m_ready   = 1'b0;
    bus.m_rdata   = 32'h1234_5678;
    for (int i = 0; i < N; i++) begin
      bus.req_addr [i*AW +: AW] = addr_tab[i];
      bus.req_wdata[i*DW +: DW] = wdata_tab[i];
      bus.req_wstrb[i*4  +: 4]  = wstrb_tab[i];
    end

    // Reset state
    do_reset();
    check("rst_grant", bus.grant, 4'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_mvalid", bus.m_valid, 1'b0);
    check("rst_maddr", bus.m_addr, 32'h0);
    check("idle_rdata_bcast", bus.req_rdata, 32'h1234_5678);

    // Single requester, one-cycle latency, three ready pulses
    bus.req_valid = 4'b0001;
    #1;
    check("latency_mvalid_before_edge", bus.m_valid, 1'b0);
    tick();
    check("latency_mvalid_after_edge", bus.m_valid, 1'b1);
    check("single_grant", bus.grant, 4'b0001);
    check("single_busy", bus.busy, 1'b1);
    check("single_maddr", bus.m_addr, 32'h0000_0100);
    for (int p = 0; p < 3; p++) begin
      exp_t e;
      e.grant = 4'b0001; e.addr = 32'h100; e.wdata = 32'hA000_0000;
      e.wstrb = 4'hF;    e.rdy  = 4'b0001; e.rdata = 32'h1234_5678;
      bus.m_ready = 1'b1;
      sbq.push_back(e);
      tick();
      bus.m_ready = 1'b0;
      #1;
      check("single_ready_low", bus.req_ready, 4'b0);
      tick();
    end
    bus.req_valid = 4'b0;
    tick();
    check("single_release", bus.grant, 4'b0);

    // All four requesting after reset: 0,1,2,3 with bubbles
    do_reset();
    bus.req_valid = 4'b1111;
    for (int o = 0; o < 4; o++) begin
      wait_grant(o);
      do_xfer(o, 32'h5500_0000 + 32'(o));
    end

    // Owner 1 holds under competing request and stalled bus
    do_reset();
    bus.req_valid = 4'b0010;
    wait_grant(1);
    bus.req_valid = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("hold_grant", bus.grant, 4'b0010);
      check("hold_req_ready", bus.req_ready, 4'b0);
    end
    do_xfer(1, 32'h0);
    wait_grant(0);
    do_xfer(0, 32'h0);

    // Read path on owner 2 (wstrb 0), leaves ptr at 3
    do_reset();
    bus.req_valid = 4'b0100;
    wait_grant(2);
    bus.m_rdata = 32'hDEAD_BEEF;
    #1;
    check("read_rdata_bcast", bus.req_rdata, 32'hDEAD_BEEF);
    check("read_wstrb", bus.m_wstrb, 4'h0);
    do_xfer(2, 32'hDEAD_BEEF);

    // Wrap: ptr=3, requests 1001 -> 3 then 0; ptr then 1 -> 0011 gives 1 first
    bus.req_valid = 4'b1001;
    wait_grant(3);
    do_xfer(3, 32'h0);
    wait_grant(0);
    do_xfer(0, 32'h0);
    bus.req_valid = 4'b0011;
    wait_grant(1);
    do_xfer(1, 32'h0);
    wait_grant(0);
    do_xfer(0, 32'h0);

    // Asynchronous reset while owner 2 active
    bus.req_valid = 4'b0100;
    wait_grant(2);
    rst = 1'b1;
    bus.m_ready = 1'b1;
    #1;
    check("arst_grant", bus.grant, 4'b0);
    check("arst_mvalid", bus.m_valid, 1'b0);
    check("arst_req_ready", bus.req_ready, 4'b0);
    check("arst_busy", bus.busy, 1'b0);
    bus.m_ready   = 1'b0;
    bus.req_valid = 4'b0101;
    tick();
    rst = 1'b0;
    wait_grant(0);
    do_xfer(0, 32'h0);
    wait_grant(2);
    do_xfer(2, 32'h0);

    tick();
    check("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
